// File: rtl/cfg_pwm_gen.sv
// Configurable PWM generator with prescaler, double-buffered duty/polarity and period status.
// Define CFG_PWM_STATUS_EN to build the completed-period counter and drive status_regs.
module cfg_pwm_gen #(
    parameter int REG_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic [2*REG_WIDTH-1:0] config_regs,
    output logic                   pwm_out,
    output logic [2*REG_WIDTH-1:0] status_regs
);

    // PRESC is 3 bits, so the terminal value never exceeds 127
    localparam int PRE_W = 8;

    logic [REG_WIDTH-1:0] duty_cfg;
    logic                 en_cfg;
    logic                 pol_cfg;
    logic [2:0]           presc;

    assign duty_cfg = config_regs[REG_WIDTH-1:0];
    assign en_cfg   = config_regs[REG_WIDTH];
    assign pol_cfg  = config_regs[REG_WIDTH+1];
    assign presc    = config_regs[REG_WIDTH+4:REG_WIDTH+2];

    logic unused_cfg;
    assign unused_cfg = ^config_regs[2*REG_WIDTH-1:REG_WIDTH+5];

    logic [PRE_W-1:0]     pre, pre_d, pre_term;
    logic [REG_WIDTH-1:0] cnt, cnt_d;
    logic [REG_WIDTH-1:0] duty_sh, duty_d, duty_use;
    logic                 pol_sh, pol_d, pol_use;
    logic                 run, run_d;
    logic                 pwm_d;
    logic                 tick, wrap;

    // >= rather than == so a shrinking PRESC retires an overshot count at once
    assign pre_term = (PRE_W'(1) << presc) - PRE_W'(1);
    assign tick     = (pre >= pre_term);
    assign wrap     = tick && (cnt == '1);

    // First enabled cycle (after EN rise or reset) compares against the live config,
    // which is also what the shadows capture on that cycle.
    assign duty_use = run ? duty_sh : duty_cfg;
    assign pol_use  = run ? pol_sh  : pol_cfg;

    always_comb begin
        pre_d  = pre;
        cnt_d  = cnt;
        duty_d = duty_sh;
        pol_d  = pol_sh;
        run_d  = run;
        pwm_d  = pwm_out;
        if (!en_cfg) begin
            pre_d  = '0;
            cnt_d  = '0;
            duty_d = duty_cfg;
            pol_d  = pol_cfg;
            run_d  = 1'b0;
            pwm_d  = pol_cfg;
        end else begin
            run_d = 1'b1;
            if (!run || wrap) begin
                duty_d = duty_cfg;
                pol_d  = pol_cfg;
            end
            pre_d = tick ? '0 : pre + PRE_W'(1);
            if (tick)
                cnt_d = cnt + REG_WIDTH'(1);
            pwm_d = (cnt < duty_use) ^ pol_use;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre     <= '0;
            cnt     <= '0;
            duty_sh <= '0;
            pol_sh  <= 1'b0;
            run     <= 1'b0;
            pwm_out <= 1'b0;
        end else if (ena) begin
            pre     <= pre_d;
            cnt     <= cnt_d;
            duty_sh <= duty_d;
            pol_sh  <= pol_d;
            run     <= run_d;
            pwm_out <= pwm_d;
        end
    end

`ifdef CFG_PWM_STATUS_EN
    logic [REG_WIDTH-1:0] pcnt;

    // Counts wraps even when EN drops on the wrapping cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pcnt <= '0;
        else if (ena && wrap)
            pcnt <= pcnt + REG_WIDTH'(1);
    end

    assign status_regs = {pcnt, cnt};
`else
    assign status_regs = '0;
`endif

endmodule

// File: tb/tb_cfg_pwm_gen.sv
module tb_cfg_pwm_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [15:0] config_regs;
    logic        pwm_out;
    logic [15:0] status_regs;

    cfg_pwm_gen #(.REG_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .config_regs (config_regs),
        .pwm_out     (pwm_out),
        .status_regs (status_regs)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          is_st;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [15:0] st(int pc, int cn);
        logic [15:0] v;
        v = {pc[7:0], cn[7:0]};
`ifndef CFG_PWM_STATUS_EN
        v = 16'h0000;
`endif
        return v;
    endfunction

    task automatic push(int c, bit s, logic [15:0] v, string n);
        exp_t e;
        e.cyc = c; e.is_st = s; e.val = v; e.name = n;
        q.push_back(e);
    endtask

    task automatic push_pwm(int c, bit v, string n);
        push(c, 1'b0, {15'd0, v}, n);
    endtask

    task automatic wait_cyc(int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    exp_t        m_e;
    logic [15:0] m_act;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m_e   = q.pop_front();
            m_act = m_e.is_st ? status_regs : {15'd0, pwm_out};
            n_chk++;
            if (m_e.cyc != cyc || m_act !== m_e.val) begin
                n_fail++;
                $display("FAIL %s at cycle %0d (due %0d): got %h, expected %h",
                         m_e.name, cyc, m_e.cyc, m_act, m_e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int base, d0, e0, f0, r, g0, o;
    bit v;

    initial begin
        rst = 1'b1; ena = 1'b1; config_regs = 16'h0240;
        wait_cyc(1);
        for (int c = 1; c <= 3; c++) begin
            push_pwm(c, 1'b0, "rst_pwm");
            push(c, 1'b1, 16'h0000, "rst_status");
        end

        wait_cyc(3);
        rst = 1'b0; config_regs = 16'h0140; base = cyc;
        for (int k = 1; k <= 768; k++) begin
            v = ((k - 1) % 256) < (((k - 1) / 256) < 2 ? 64 : 192);
            push_pwm(base + k, v, "duty_pwm");
            if (k == 1 || k == 64 || k == 100 || k == 255 || k == 256 ||
                k == 257 || k == 512 || k == 768)
                push(base + k, 1'b1, st(k / 256, k % 256), "duty_status");
        end
        wait_cyc(base + 356);
        config_regs = 16'h01C0;
        wait_cyc(base + 768);

        config_regs = 16'h0080;
        push_pwm(cyc + 1, 1'b0, "en0_pwm");
        push(cyc + 1, 1'b1, st(3, 0), "en0_status");
        wait_cyc(cyc + 1);
        config_regs = 16'h0D80; d0 = cyc;
        for (int k = 1; k <= 1795; k++) begin
            v = (k <= 1023) || (k >= 1280 && k <= 1535) || (k >= 1792);
            push_pwm(d0 + k, v, "presc_pwm");
            if (k == 1022) push(d0 + k, 1'b1, st(3, 127), "presc_status");
            if (k == 1023) push(d0 + k, 1'b1, st(3, 128), "presc_status");
            if (k == 1279) push(d0 + k, 1'b1, st(4, 0),   "presc_status");
            if (k == 1791) push(d0 + k, 1'b1, st(5, 0),   "presc_status");
        end
        wait_cyc(d0 + 1022);
        config_regs = 16'h0580;
        wait_cyc(d0 + 1795);

        config_regs = 16'h0200; e0 = cyc + 1;
        for (int j = 0; j <= 301; j++) begin
            push_pwm(e0 + j, 1'b1, "pol_pwm");
            if (j == 0)   push(e0 + j, 1'b1, st(5, 0),   "pol_status");
            if (j == 100) push(e0 + j, 1'b1, st(5, 100), "pol_status");
            if (j == 256) push(e0 + j, 1'b1, st(6, 0),   "pol_status");
            if (j == 301) push(e0 + j, 1'b1, st(6, 45),  "pol_status");
        end
        wait_cyc(e0);
        config_regs = 16'h0300;
        wait_cyc(e0 + 301);

        config_regs = 16'h00D0; f0 = cyc + 1;
        push_pwm(f0, 1'b0, "ena_pwm");
        push(f0, 1'b1, st(6, 0), "ena_status");
        for (int j = 1; j <= 505; j++) begin
            o = (j <= 208) ? j : ((j <= 258) ? 208 : j - 50);
            push_pwm(f0 + j, ((o - 1) % 256) < 208, "ena_pwm");
            if (j == 208 || j == 230 || j == 258)
                push(f0 + j, 1'b1, st(6, 208), "ena_status");
            if (j == 259) push(f0 + j, 1'b1, st(6, 209), "ena_status");
            if (j == 306) push(f0 + j, 1'b1, st(7, 0),   "ena_status");
            if (j == 505) push(f0 + j, 1'b1, st(7, 199), "ena_status");
        end
        wait_cyc(f0);
        config_regs = 16'h01D0;
        wait_cyc(f0 + 208);
        ena = 1'b0;
        wait_cyc(f0 + 258);
        ena = 1'b1;

        r = f0 + 506;
        for (int c = r; c <= r + 2; c++) begin
            push_pwm(c, 1'b0, "async_rst_pwm");
            push(c, 1'b1, 16'h0000, "async_rst_status");
        end
        wait_cyc(r);
        #1 rst = 1'b1;
        #1;
        n_chk++;
        if (pwm_out !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_immediate_pwm: got %b, expected 0", pwm_out);
        end
        n_chk++;
        if (status_regs !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_rst_immediate_status: got %h, expected 0000", status_regs);
        end
        wait_cyc(r + 2);
        rst = 1'b0; g0 = cyc;
        for (int j = 1; j <= 257; j++) begin
            push_pwm(g0 + j, ((j - 1) % 256) < 208, "restart_pwm");
            if (j == 1)   push(g0 + j, 1'b1, st(0, 1),   "restart_status");
            if (j == 200) push(g0 + j, 1'b1, st(0, 200), "restart_status");
            if (j == 256) push(g0 + j, 1'b1, st(1, 0),   "restart_status");
        end
        wait_cyc(g0 + 258);

        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expectations never checked", q.size());
        end
        if (n_chk < 12) begin
            n_fail++;
            $display("FAIL check_count: only %0d checks ran", n_chk);
        end
        if (n_fail != 0)
            $display("FAIL summary: %0d failures", n_fail);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
